// File: rtl/sr_latch_pulse_driver.sv
// Turns single-cycle set/clear requests into clean, width-guaranteed low pulses on SIN/RIN of an SR NAND latch.
// Optional readback check of the latch Q/QN is enabled with `define SRDRV_READBACK_EN.
module sr_latch_pulse_driver #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic req_valid,
  input  logic req_set,
  output logic req_ready,
  output logic sin,
  output logic rin,
  input  logic q_fb,
  input  logic qn_fb,
  output logic done,
  output logic err
);

`ifdef SRDRV_READBACK_EN
  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
`endif

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             set_reg;
  logic             sin_reg;
  logic             rin_reg;
  logic             ready_reg;
  logic             done_reg;

`ifdef SRDRV_READBACK_EN
  logic q_meta_reg, q_sync_reg, qn_meta_reg, qn_sync_reg;
  logic err_reg;

  // Feedback comes straight from the latch cell, so it is resynchronised first.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q_meta_reg  <= 1'b0;
      q_sync_reg  <= 1'b0;
      qn_meta_reg <= 1'b0;
      qn_sync_reg <= 1'b0;
    end else begin
      q_meta_reg  <= q_fb;
      q_sync_reg  <= q_meta_reg;
      qn_meta_reg <= qn_fb;
      qn_sync_reg <= qn_meta_reg;
    end
  end

  assign err = err_reg;
`else
  wire unused_fb = q_fb ^ qn_fb;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      set_reg   <= 1'b0;
      sin_reg   <= 1'b1;
      rin_reg   <= 1'b1;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SRDRV_READBACK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (req_valid && ready_reg) begin
            set_reg   <= req_set;
            cnt_reg   <= PULSE_LOAD;
            state_reg <= PULSE;
            ready_reg <= 1'b0;
            // Exactly one line is driven low, picked by the request type.
            sin_reg   <= ~req_set;
            rin_reg   <= req_set;
          end
        end
        PULSE: begin
          if (cnt_reg == '0) begin
            cnt_reg   <= GAP_LOAD;
            state_reg <= GAP;
            sin_reg   <= 1'b1;
            rin_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_reg == '0) begin
`ifdef SRDRV_READBACK_EN
            cnt_reg   <= CNT_ONE;
            state_reg <= CHECK;
`else
            state_reg <= IDLE;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
`endif
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
`ifdef SRDRV_READBACK_EN
        CHECK: begin
          if (cnt_reg == '0) begin
            if ((q_sync_reg != set_reg) || (qn_sync_reg != ~set_reg))
              err_reg <= 1'b1;
            state_reg <= IDLE;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          sin_reg   <= 1'b1;
          rin_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign sin       = sin_reg;
  assign rin       = rin_reg;
  assign req_ready = ready_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_sr_latch_pulse_driver.sv
// Directed bench for sr_latch_pulse_driver: default instance (2/1) plus a 5/3 instance, each with a latch model on the feedback.
module tb_sr_latch_pulse_driver;

`ifdef SRDRV_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 0;
`endif
  localparam int PW    = 2;
  localparam int GW    = 1;
  localparam int LAT   = PW + GW + 1 + RB;
  localparam int PW_B  = 5;
  localparam int GW_B  = 3;
  localparam int LAT_B = PW_B + GW_B + 1 + RB;

  logic clk = 1'b0;
  logic rstb, req_valid, req_set, req_ready, sin, rin, q_fb, qn_fb, done, err;
  logic req_valid_b, req_set_b, req_ready_b, sin_b, rin_b, q_fb_b, qn_fb_b, done_b, err_b;
  logic lq = 1'b0;
  logic lq_b = 1'b0;
  logic force_q0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_latch_pulse_driver dut (
    .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_set(req_set), .req_ready(req_ready),
    .sin(sin), .rin(rin), .q_fb(q_fb), .qn_fb(qn_fb), .done(done), .err(err)
  );

  sr_latch_pulse_driver #(.PULSE_W(PW_B), .GAP_W(GW_B), .CNT_W(4)) dut_b (
    .clk(clk), .rstb(rstb), .req_valid(req_valid_b), .req_set(req_set_b), .req_ready(req_ready_b),
    .sin(sin_b), .rin(rin_b), .q_fb(q_fb_b), .qn_fb(qn_fb_b), .done(done_b), .err(err_b)
  );

  // Latch models: a low SIN sets Q, a low RIN clears it.
  always @(posedge clk) begin
    if (!sin) lq <= 1'b1;
    else if (!rin) lq <= 1'b0;
    if (!sin_b) lq_b <= 1'b1;
    else if (!rin_b) lq_b <= 1'b0;
  end
  assign q_fb    = force_q0 ? 1'b0 : lq;
  assign qn_fb   = ~lq;
  assign q_fb_b  = lq_b;
  assign qn_fb_b = ~lq_b;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check every cycle from accept to the DONE cycle.
  task automatic run_one(input logic s, input logic hold, input logic nxt, input logic poke);
    req_valid = 1'b1;
    req_set   = s;
    check("ready_at_accept", req_ready, 1'b1);
    tick();
    if (!hold) req_valid = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      check("sin", sin, (s && i <= PW) ? 1'b0 : 1'b1);
      check("rin", rin, (!s && i <= PW) ? 1'b0 : 1'b1);
      check("done", done, i == LAT);
      check("ready", req_ready, i == LAT);
      check("never_both_low", sin | rin, 1'b1);
      if (poke) begin
        if (i == 1) begin
          req_valid = 1'b1;
          req_set   = ~s;
        end else if (i == 2) begin
          req_valid = 1'b0;
        end
      end
      if (i == LAT && hold) req_set = nxt;
      if (i < LAT) tick();
    end
    $display("req set=%0b hold=%0b poke=%0b done_at=%0d err=%0b", s, hold, poke, LAT, err);
  endtask

  initial begin
    rstb = 1'b0; req_valid = 1'b0; req_set = 1'b0;
    req_valid_b = 1'b0; req_set_b = 1'b0; force_q0 = 1'b0;
    repeat (3) tick();
    check("rst_sin", sin, 1'b1);
    check("rst_rin", rin, 1'b1);
    check("rst_ready", req_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sin_b", sin_b, 1'b1);
    $display("reset held: sin=%0b rin=%0b ready=%0b", sin, rin, req_ready);

    rstb = 1'b1;
    check("ready_in_release_cycle", req_ready, 1'b0);
    tick();
    check("ready_after_release", req_ready, 1'b1);
    check("ready_after_release_b", req_ready_b, 1'b1);

    run_one(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle_done_low", done, 1'b0);
    check("idle_sin_high", sin, 1'b1);
    check("err_after_set", err, 1'b0);

    // Back-to-back: clear then set, second accept lands in the DONE cycle.
    run_one(1'b0, 1'b1, 1'b1, 1'b0);
    run_one(1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // A request poked while busy must not produce another pulse.
    run_one(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_ignored_sin", sin, 1'b1);
      check("busy_ignored_rin", rin, 1'b1);
      check("busy_ignored_done", done, 1'b0);
    end
    $display("busy poke ignored checked");

    // Reset mid-pulse releases SIN without a clock edge.
    req_valid = 1'b1; req_set = 1'b1;
    tick();
    req_valid = 1'b0;
    check("midpulse_sin_low", sin, 1'b0);
    #3 rstb = 1'b0;
    #1;
    check("async_sin_release", sin, 1'b1);
    check("async_ready_low", req_ready, 1'b0);
    tick();
    check("rst_hold_ready", req_ready, 1'b0);
    check("rst_hold_sin", sin, 1'b1);
    rstb = 1'b1;
    tick();
    check("ready_after_rerelease", req_ready, 1'b1);
    $display("reset mid-pulse checked");

    // 5/3 instance: clear request.
    req_valid_b = 1'b1; req_set_b = 1'b0;
    check("b_ready_at_accept", req_ready_b, 1'b1);
    tick();
    req_valid_b = 1'b0;
    for (int i = 1; i <= LAT_B; i++) begin
      check("b_rin", rin_b, (i <= PW_B) ? 1'b0 : 1'b1);
      check("b_sin", sin_b, 1'b1);
      check("b_done", done_b, i == LAT_B);
      if (i < LAT_B) tick();
    end
    $display("req_b set=0 done_at=%0d", LAT_B);
    tick();

    // Feedback forced wrong during a set: flags only when readback is built in, and stays set.
    force_q0 = 1'b1;
    run_one(1'b1, 1'b0, 1'b0, 1'b0);
    check("err_on_mismatch", err, RB != 0);
    force_q0 = 1'b0;
    tick();
    run_one(1'b0, 1'b0, 1'b0, 1'b0);
    check("err_sticky", err, RB != 0);
    rstb = 1'b0;
    tick();
    check("err_cleared_by_reset", err, 1'b0);
    rstb = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_latch_pulse_driver.md
Name: sr_latch_pulse_driver

Overview:
- Synchronous front-end that drives the active-low set (SIN) and reset (RIN) inputs of an SR NAND latch cell.
- Converts single-cycle set/clear requests into clean low pulses of guaranteed minimum width. A guard gap follows each pulse, which meets the latch's pulse-width and SIN/RIN setup/hold checks.
- SIN and RIN are never low at the same time.
- Sits directly upstream of the latch cell. Optionally reads the latch's Q/QN back to confirm the write.

Parameters:
- PULSE_W, 2, cycles the selected line is held low; legal range 1..15.
- GAP_W, 1, cycles both lines are held high after a pulse before the next request is accepted; legal range 1..15.
- CNT_W, 4, width of the internal phase counter; must hold max(PULSE_W, GAP_W).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RSTB  input  1  asynchronous, active-low reset.
- REQ_VALID  input  1  request present.
- REQ_SET  input  1  request type: 1 = set (pulse SIN low, latch Q -> 1), 0 = clear (pulse RIN low, latch Q -> 0).
- REQ_READY  output  1  block can accept a request this cycle.
- SIN  output  1  active-low set drive to the latch; registered.
- RIN  output  1  active-low reset drive to the latch; registered.
- Q_FB  input  1  latch Q readback; asynchronous to CLK; used only with the readback option.
- QN_FB  input  1  latch QN readback; asynchronous to CLK; used only with the readback option.
- DONE  output  1  one-cycle pulse when a request completes.
- ERR  output  1  sticky readback-mismatch flag.

Behaviour:
- Reset (RSTB low, asynchronous):
  - SIN=1, RIN=1, REQ_READY=0, DONE=0, ERR=0.
  - FSM goes to IDLE; counter=0; stored request type=0.
  - In the first clock after RSTB deasserts, REQ_READY rises to 1.
  - Reset asserted mid-pulse releases SIN/RIN to 1 immediately, without waiting for a clock edge.
- FSM states: IDLE, PULSE, GAP, CHECK (CHECK exists only with the readback option).
- IDLE:
  - REQ_READY=1.
  - Handshake: a request is accepted on a rising edge where REQ_VALID=1 and REQ_READY=1.
  - On accept: latch REQ_SET, load counter with PULSE_W-1, go to PULSE.
  - REQ_VALID=0 leaves the FSM in IDLE.
- PULSE:
  - SIN=~set_q and RIN=set_q, i.e. only the selected line is 0. The line goes low in the cycle after acceptance.
  - REQ_READY=0.
  - Counter decrements each cycle. At 0: load GAP_W-1 and go to GAP.
  - The selected line is low for exactly PULSE_W cycles.
- GAP:
  - SIN=RIN=1, REQ_READY=0.
  - Counter decrements each cycle. At 0: go to CHECK if readback is enabled, else go to IDLE.
- Completion:
  - On the transition into IDLE from GAP or CHECK, DONE=1 for exactly one cycle.
  - REQ_READY=1 in that same cycle.
  - A new request may be accepted in the DONE cycle (back-to-back operation).
- Latency without readback: accept edge to DONE cycle = PULSE_W+GAP_W+1 cycles.
- Request rules:
  - REQ_VALID/REQ_SET are ignored while REQ_READY=0. No queueing; the requester must hold the request until accepted.
  - A request equal to the current latch state is still executed; it is not filtered.
  - Only one request is taken per handshake, so there is no set/clear conflict.
- Invariant: SIN=0 and RIN=0 together is illegal in every state, including during reset entry and exit.
- Outputs are glitch-free: SIN and RIN come directly from flops with no combinational logic after the flop.

Optional Feature:
- Macro: SRDRV_READBACK_EN.
- Defined:
  - Q_FB and QN_FB each pass through a 2-flop synchronizer, reset to 0.
  - CHECK lasts 2 cycles with SIN=RIN=1.
  - On the last CHECK cycle, synced Q_FB must equal set_q and synced QN_FB must equal ~set_q. Any mismatch sets ERR=1.
  - ERR is sticky until RSTB.
  - DONE still pulses on completion.
  - Latency becomes PULSE_W+GAP_W+3 cycles.
- Not defined:
  - No CHECK state and no synchronizers; Q_FB and QN_FB are unused.
  - ERR is tied to 0.

Test Plan:
- Reset, defaults: RSTB low, then release -> SIN=1, RIN=1, DONE=0, ERR=0 during reset. REQ_READY=1 one clock after release.
- Set request, defaults: REQ_VALID=1, REQ_SET=1 for one cycle -> SIN=0 for exactly 2 cycles starting the next cycle, RIN stays 1, then 1 gap cycle, then DONE=1 for 1 cycle. DONE arrives 4 cycles after accept (no readback).
- Back-to-back requests: clear then set, REQ_VALID held high -> RIN low 2 cycles, gap, DONE, then SIN low 2 cycles. No cycle has both low. The second accept happens in the DONE cycle.
- Busy-time and reset handling:
  - REQ_VALID pulsed during PULSE -> ignored; no extra pulse.
  - RSTB pulsed low mid-PULSE -> SIN returns to 1 asynchronously and REQ_READY=0 while reset is held.
- PULSE_W=5, GAP_W=3 -> selected line low exactly 5 cycles, 3 gap cycles, DONE 9 cycles after accept.
- With SRDRV_READBACK_EN, latch model connected:
  - Set request -> DONE at 6 cycles, ERR=0.
  - Q_FB forced to 0 during a set request -> ERR=1 and stays 1 until RSTB.
